// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU arbiter: the idu1 control bundle, ALU opcodes,
// arbiter state encoding and a helper producing the idle (nop) bundle.
package alu_arb_pkg;

    localparam int XLEN          = 32;
    localparam int ALU_ARB_PORTS = 2;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR
    } alu_op_e;

    typedef struct packed {
        logic            nop;
        alu_op_e         alu_op;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [4:0]      rd_addr;
        logic            rd_wr_en;
        logic [XLEN-1:0] instr_tag;
    } idu1_out_t;

    typedef enum logic {
        NORM,
        FORCE
    } alu_arb_state_e;

    function automatic idu1_out_t nop_bundle();
        idu1_out_t b;
        b     = '0;
        b.nop = 1'b1;
        return b;
    endfunction

endpackage

// File: rtl/alu_arb_own_pipe.sv
// Result-ownership shift register: tracks {vld, owner} of each issued op
// through the ALU latency; clr kills everything in flight on the next edge.
module alu_arb_own_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic in_vld,
    input  logic in_owner,
    output logic out_vld,
    output logic out_owner
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [DEPTH-1:0] owner_q;
    logic [DEPTH-1:0] owner_d;

    always_comb begin
        vld_d      = '0;
        owner_d    = '0;
        vld_d[0]   = in_vld;
        owner_d[0] = in_owner;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i]   = vld_q[i-1];
            owner_d[i] = owner_q[i-1];
        end
        if (clr) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            owner_q <= '0;
        end else begin
            vld_q   <= vld_d;
            owner_q <= owner_d;
        end
    end

    assign out_vld   = vld_q[DEPTH-1];
    assign out_owner = owner_q[DEPTH-1];

endmodule

// File: rtl/alu_arb.sv
// Two-port ALU issue arbiter: port 0 priority with a starvation guard for
// port 1, plus result steering. ALU_ARB_PERF_EN adds saturating perf counters.
module alu_arb
    import alu_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int ALU_LAT  = 1
`ifdef ALU_ARB_PERF_EN
    ,
    parameter int PERF_W   = 32
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  idu1_out_t       req0_ctrl,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  idu1_out_t       req1_ctrl,
    output idu1_out_t       alu_ctrl,
    input  logic [XLEN-1:0] alu_wb_data,
    input  logic [4:0]      alu_wb_rd_addr,
    input  logic            alu_wb_rd_wr_en,
    input  logic [XLEN-1:0] alu_instr_tag,
    output logic            rsp0_valid,
    output logic            rsp1_valid,
    output logic [XLEN-1:0] rsp_data,
    output logic [4:0]      rsp_rd_addr,
    output logic            rsp_wr_en,
    output logic [XLEN-1:0] rsp_tag
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_grant0,
    output logic [PERF_W-1:0] perf_grant1,
    output logic [PERF_W-1:0] perf_conflict,
    output logic [PERF_W-1:0] perf_force
`endif
);

    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    alu_arb_state_e state_q;
    alu_arb_state_e state_d;
    logic [3:0]     wait_cnt_q;
    logic [3:0]     wait_cnt_d;
    logic           kill;
    logic           grant0;
    logic           grant1;
    logic           own_vld;
    logic           own_owner;
    logic           rsp_vld;

    assign kill = rst | flush;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        grant0     = 1'b0;
        grant1     = 1'b0;
        unique case (state_q)
            NORM: begin
                grant0 = req0_valid & ~kill;
                grant1 = req1_valid & ~req0_valid & ~kill;
                if (!req1_valid || grant1) begin
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = FORCE;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            FORCE: begin
                grant1     = req1_valid & ~kill;
                wait_cnt_d = '0;
                state_d    = NORM;
            end
        endcase
        // flush also cancels a pending forced grant
        if (flush) begin
            state_d    = NORM;
            wait_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= NORM;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        alu_ctrl = nop_bundle();
        unique case (1'b1)
            grant0:  alu_ctrl = req0_ctrl;
            grant1:  alu_ctrl = req1_ctrl;
            default: ;
        endcase
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    alu_arb_own_pipe #(
        .DEPTH(ALU_LAT)
    ) u_own_pipe (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .in_vld   (grant0 | grant1),
        .in_owner (grant1),
        .out_vld  (own_vld),
        .out_owner(own_owner)
    );

    // a result landing in the flush cycle was issued before the flush
    assign rsp_vld     = own_vld & ~flush;
    assign rsp0_valid  = rsp_vld & ~own_owner;
    assign rsp1_valid  = rsp_vld & own_owner;
    assign rsp_data    = alu_wb_data;
    assign rsp_rd_addr = alu_wb_rd_addr;
    assign rsp_wr_en   = alu_wb_rd_wr_en & rsp_vld;
    assign rsp_tag     = alu_instr_tag;

`ifdef ALU_ARB_PERF_EN
    logic [PERF_W-1:0] pg0_q, pg0_d;
    logic [PERF_W-1:0] pg1_q, pg1_d;
    logic [PERF_W-1:0] pcf_q, pcf_d;
    logic [PERF_W-1:0] pfc_q, pfc_d;

    function automatic logic [PERF_W-1:0] sat_inc(
        input logic [PERF_W-1:0] c,
        input logic              en
    );
        return (en && !(&c)) ? c + PERF_W'(1) : c;
    endfunction

    always_comb begin
        pg0_d = sat_inc(pg0_q, grant0);
        pg1_d = sat_inc(pg1_q, grant1);
        pcf_d = sat_inc(pcf_q, req0_valid & req1_valid);
        pfc_d = sat_inc(pfc_q, (state_q == NORM) && (state_d == FORCE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pg0_q <= '0;
            pg1_q <= '0;
            pcf_q <= '0;
            pfc_q <= '0;
        end else begin
            pg0_q <= pg0_d;
            pg1_q <= pg1_d;
            pcf_q <= pcf_d;
            pfc_q <= pfc_d;
        end
    end

    assign perf_grant0   = pg0_q;
    assign perf_grant1   = pg1_q;
    assign perf_conflict = pcf_q;
    assign perf_force    = pfc_q;
`endif

endmodule

// File: tb/tb_alu_arb.sv
// Vector-table bench for alu_arb with a 1-cycle ALU model and a result
// scoreboard; perf counters are checked when ALU_ARB_PERF_EN is defined.
module tb_alu_arb;
    import alu_arb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            flush;
    logic            req0_valid;
    logic            req0_ready;
    logic            req1_valid;
    logic            req1_ready;
    idu1_out_t       req0_ctrl;
    idu1_out_t       req1_ctrl;
    idu1_out_t       alu_ctrl;
    logic [XLEN-1:0] alu_wb_data;
    logic [4:0]      alu_wb_rd_addr;
    logic            alu_wb_rd_wr_en;
    logic [XLEN-1:0] alu_instr_tag;
    logic            rsp0_valid;
    logic            rsp1_valid;
    logic [XLEN-1:0] rsp_data;
    logic [4:0]      rsp_rd_addr;
    logic            rsp_wr_en;
    logic [XLEN-1:0] rsp_tag;
`ifdef ALU_ARB_PERF_EN
    logic [31:0]     perf_grant0;
    logic [31:0]     perf_grant1;
    logic [31:0]     perf_conflict;
    logic [31:0]     perf_force;
`endif

    alu_arb #(
        .MAX_WAIT(4),
        .ALU_LAT (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_ctrl      (req0_ctrl),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_ctrl      (req1_ctrl),
        .alu_ctrl       (alu_ctrl),
        .alu_wb_data    (alu_wb_data),
        .alu_wb_rd_addr (alu_wb_rd_addr),
        .alu_wb_rd_wr_en(alu_wb_rd_wr_en),
        .alu_instr_tag  (alu_instr_tag),
        .rsp0_valid     (rsp0_valid),
        .rsp1_valid     (rsp1_valid),
        .rsp_data       (rsp_data),
        .rsp_rd_addr    (rsp_rd_addr),
        .rsp_wr_en      (rsp_wr_en),
        .rsp_tag        (rsp_tag)
`ifdef ALU_ARB_PERF_EN
        ,
        .perf_grant0    (perf_grant0),
        .perf_grant1    (perf_grant1),
        .perf_conflict  (perf_conflict),
        .perf_force     (perf_force)
`endif
    );

    function automatic logic [31:0] alu_ref(
        input alu_op_e op, input logic [31:0] a, input logic [31:0] b
    );
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            default: return 32'h0;
        endcase
    endfunction

    // registered single-cycle ALU sitting behind the arbiter
    always_ff @(posedge clk) begin
        alu_wb_data     <= alu_ref(alu_ctrl.alu_op, alu_ctrl.rs1_val,
                                   alu_ctrl.rs2_val);
        alu_wb_rd_addr  <= alu_ctrl.rd_addr;
        alu_wb_rd_wr_en <= alu_ctrl.rd_wr_en & ~alu_ctrl.nop;
        alu_instr_tag   <= alu_ctrl.instr_tag;
    end

    typedef struct {
        bit          rst;
        bit          flush;
        bit          v0;
        bit          v1;
        bit          r0;
        bit          r1;
        alu_op_e     op0;
        alu_op_e     op1;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [4:0]  rd0;
        logic [4:0]  rd1;
    } vec_t;

    typedef struct {
        int          due;
        bit          port;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [31:0] tag;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   cyc;
    int   n_cmp;
    int   n_bad;

    function automatic vec_t V(
        input bit rs, input bit fl, input bit v0, input bit v1,
        input bit r0, input bit r1, input int k
    );
        vec_t v;
        v.rst   = rs;
        v.flush = fl;
        v.v0    = v0;
        v.v1    = v1;
        v.r0    = r0;
        v.r1    = r1;
        v.op0   = alu_op_e'(3'(k % 5));
        v.a0    = 32'h100 + 32'(k * 7);
        v.b0    = 32'(k + 3);
        v.rd0   = 5'(k + 1);
        v.op1   = alu_op_e'(3'((k + 2) % 5));
        v.a1    = 32'h5000 + 32'(k);
        v.b1    = 32'(k * 11);
        v.rd1   = 5'(k + 16);
        return v;
    endfunction

    function automatic idu1_out_t mk_ctrl(
        input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
        input logic [4:0] rd, input logic [31:0] tag
    );
        idu1_out_t c;
        c           = '0;
        c.alu_op    = op;
        c.rs1_val   = a;
        c.rs2_val   = b;
        c.rd_addr   = rd;
        c.rd_wr_en  = 1'b1;
        c.instr_tag = tag;
        return c;
    endfunction

    task automatic chk(
        input string name, input logic [63:0] act, input logic [63:0] exp
    );
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got 0x%0h, want 0x%0h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        idu1_out_t c0;
        idu1_out_t c1;
        idu1_out_t ea;
        exp_t      e;
        c0 = mk_ctrl(v.op0, v.a0, v.b0, v.rd0, 32'hA000_0000 | 32'(cyc));
        c1 = mk_ctrl(v.op1, v.a1, v.b1, v.rd1, 32'hB000_0000 | 32'(cyc));
        @(negedge clk);
        rst        = v.rst;
        flush      = v.flush;
        req0_valid = v.v0;
        req1_valid = v.v1;
        req0_ctrl  = c0;
        req1_ctrl  = c1;
        #1;
        chk("req0_ready", 64'(req0_ready), 64'(v.r0));
        chk("req1_ready", 64'(req1_ready), 64'(v.r1));
        ea = v.r0 ? c0 : (v.r1 ? c1 : nop_bundle());
        chk("alu_nop", 64'(alu_ctrl.nop), 64'(ea.nop));
        chk("alu_tag", 64'(alu_ctrl.instr_tag), 64'(ea.instr_tag));
        chk("alu_rs1", 64'(alu_ctrl.rs1_val), 64'(ea.rs1_val));
        if (v.rst) begin
            sb.delete();
        end else begin
            if (v.flush) sb.delete();
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("rsp0_valid", 64'(rsp0_valid), 64'(!e.port));
                chk("rsp1_valid", 64'(rsp1_valid), 64'(e.port));
                chk("rsp_data", 64'(rsp_data), 64'(e.data));
                chk("rsp_rd_addr", 64'(rsp_rd_addr), 64'(e.rd));
                chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
                chk("rsp_wr_en", 64'(rsp_wr_en), 64'(1));
            end else begin
                chk("rsp0_idle", 64'(rsp0_valid), 64'(0));
                chk("rsp1_idle", 64'(rsp1_valid), 64'(0));
                chk("wr_en_idle", 64'(rsp_wr_en), 64'(0));
            end
            if (v.r0 || v.r1) begin
                e.due  = cyc + 1;
                e.port = v.r1;
                e.data = v.r1 ? alu_ref(v.op1, v.a1, v.b1)
                              : alu_ref(v.op0, v.a0, v.b0);
                e.rd   = v.r1 ? v.rd1 : v.rd0;
                e.tag  = v.r1 ? c1.instr_tag : c0.instr_tag;
                sb.push_back(e);
            end
        end
        cyc++;
    endtask

    task automatic add(
        input bit rs, input bit fl, input bit v0, input bit v1,
        input bit r0, input bit r1
    );
        tbl.push_back(V(rs, fl, v0, v1, r0, r1, tbl.size()));
    endtask

    initial begin
        vec_t v;
        rst        = 1'b1;
        flush      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_ctrl  = nop_bundle();
        req1_ctrl  = nop_bundle();
        cyc        = 0;
        n_cmp      = 0;
        n_bad      = 0;

        // reset with both requesting: no grants, nop to ALU
        add(1, 0, 1, 1, 0, 0);
        add(1, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        // lone port 1 ADD 5+7 -> rd 3
        v = V(0, 0, 0, 1, 0, 1, tbl.size());
        v.op1 = ALU_ADD;
        v.a1  = 32'd5;
        v.b1  = 32'd7;
        v.rd1 = 5'd3;
        tbl.push_back(v);
        add(0, 0, 0, 0, 0, 0);
        // both valid: period 5, forced port 1 every 5th cycle
        for (int i = 0; i < 10; i++) add(0, 0, 1, 1, i % 5 != 4, i % 5 == 4);
        add(0, 0, 0, 0, 0, 0);
        // alternate owners with rd 1/2/4
        v = V(0, 0, 1, 0, 1, 0, tbl.size());
        v.rd0 = 5'd1;
        tbl.push_back(v);
        v = V(0, 0, 0, 1, 0, 1, tbl.size());
        v.rd1 = 5'd2;
        tbl.push_back(v);
        v = V(0, 0, 1, 0, 1, 0, tbl.size());
        v.rd0 = 5'd4;
        tbl.push_back(v);
        add(0, 0, 0, 0, 0, 0);
        // flush right after a port 0 grant
        add(0, 0, 1, 0, 1, 0);
        add(0, 1, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        // flush clears a partly built wait count
        for (int i = 0; i < 3; i++) add(0, 0, 1, 1, 1, 0);
        add(0, 1, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 1, 1, 1, 0);
        add(0, 0, 1, 1, 0, 1);
        // flush overrides a pending FORCE
        for (int i = 0; i < 4; i++) add(0, 0, 1, 1, 1, 0);
        add(0, 1, 1, 1, 0, 0);
        add(0, 0, 1, 1, 1, 0);
        // idle stretch
        for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 0, 0);

        foreach (tbl[i]) apply(tbl[i]);

        // reset while a result is in flight, then restart arbitration
        apply(V(0, 0, 1, 0, 1, 0, 200));
        apply(V(1, 0, 1, 1, 0, 0, 201));
        apply(V(0, 0, 0, 0, 0, 0, 202));
        for (int i = 0; i < 4; i++) apply(V(0, 0, 1, 1, 1, 0, 203 + i));
        apply(V(0, 0, 1, 1, 0, 1, 207));
        apply(V(0, 0, 0, 0, 0, 0, 208));
`ifdef ALU_ARB_PERF_EN
        chk("perf_grant0", 64'(perf_grant0), 64'(4));
        chk("perf_grant1", 64'(perf_grant1), 64'(1));
        chk("perf_conflict", 64'(perf_conflict), 64'(5));
        chk("perf_force", 64'(perf_force), 64'(1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
